tensor_ram_writer: RTL

- Consumer end of the STA output stream. Accepts one int8 result per cycle, either as a pooled (row, col) pixel for the current output channel or as a dense-layer index.
- Converts each result to a tensor-RAM byte address, buffers it in a small FIFO, merges bytes that land in the same 32-bit word, and issues byte-enabled word writes under a ready handshake.
- Asserts stall_req upstream before the FIFO can overflow, and reports drain completion to the layer controller.

---
 rtl/tensor_ram_writer_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/tensor_ram_writer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_ram_writer_pkg.sv
// Shared types for the tensor-RAM writer: byte type, FIFO entry layout, FSM states.
package tensor_ram_writer_pkg;

  localparam int TRW_WORD_BYTES = 4;
  localparam int TRW_LANE_BITS  = $clog2(TRW_WORD_BYTES);
  localparam int TRW_ADDR_BITS  = 14;

  typedef logic [7:0] int8_t;

  // One buffered result: target word, byte lane within it, and the byte itself.
  typedef struct packed {
    logic [TRW_ADDR_BITS-1:0] word;
    logic [TRW_LANE_BITS-1:0] lane;
    int8_t                    val;
  } trw_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } trw_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; push-when-full and
// pop-when-empty are ignored. Head data is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/tensor_ram_writer.sv
// Tail of the STA output stream: turns int8 results into tensor-RAM byte
// addresses, queues them, merges bytes of the same word and issues
// byte-enabled word writes under a ready handshake.
module tensor_ram_writer
  import tensor_ram_writer_pkg::*;
#(
  parameter int MAX_N           = 64,
  parameter int N_BITS          = $clog2(MAX_N),
  parameter int MAX_NUM_CH      = 64,
  parameter int CH_BITS         = $clog2(MAX_NUM_CH + 1),
  parameter int BYPASS_IDX_BITS = 6,
  parameter int ADDR_BITS       = TRW_ADDR_BITS,  // entry word field is sized from the package
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_BITS-1:0]       cfg_base_addr,
  input  logic [N_BITS:0]            cfg_img_w,
  input  logic [CH_BITS-1:0]         cfg_num_ch,
  input  logic [CH_BITS-1:0]         cfg_out_ch,
  input  logic                       cfg_dense,
  input  logic                       in_valid,
  input  logic [7:0]                 in_val,
  input  logic [N_BITS-1:0]          in_row,
  input  logic [N_BITS-1:0]          in_col,
  input  logic [BYPASS_IDX_BITS-1:0] in_index,
  input  logic                       flush,
  output logic                       stall_req,
  output logic                       ram_we,
  output logic [ADDR_BITS-1:0]       ram_addr,
  output logic [8*TRW_WORD_BYTES-1:0] ram_wdata,
  output logic [TRW_WORD_BYTES-1:0]  ram_be,
  input  logic                       ram_ready,
  output logic                       done,
  output logic                       idle,
  output logic                       overflow,
  output logic [15:0]                write_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DW    = 8 * TRW_WORD_BYTES;

  trw_state_e state_q, state_d;

  // Configuration captured at start.
  logic [ADDR_BITS-1:0] base_q;
  logic [N_BITS:0]      img_w_q;
  logic [CH_BITS-1:0]   num_ch_q, out_ch_q;
  logic                 dense_q;

  // Stage A: registered byte address.
  logic                 a_vld_q;
  logic [ADDR_BITS+1:0] a_addr_q, a_addr_d;
  int8_t                a_val_q;
  logic [31:0]          pix_idx, offset, byte_full;

  // FIFO interface.
  trw_entry_t           push_ent, head;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]     fifo_count;

  // Combiner pending word and output register.
  logic                 pend_vld_q, pend_vld_d;
  logic [ADDR_BITS-1:0] pend_addr_q, pend_addr_d;
  logic [DW-1:0]        pend_data_q, pend_data_d;
  logic [TRW_WORD_BYTES-1:0] pend_be_q, pend_be_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0]        ram_wdata_q, ram_wdata_d;
  logic [TRW_WORD_BYTES-1:0] ram_be_q, ram_be_d;
  logic                 overflow_q;
  logic [15:0]          wcount_q;

  logic accept, start_ok, xfer, head_vld, merge_ok, load, drain_end, issue;
  logic [DW-1:0]             head_data;
  logic [TRW_WORD_BYTES-1:0] head_be;

  assign start_ok  = start && (state_q == ST_IDLE);
  assign accept    = in_valid && (state_q == ST_RUN);
  assign xfer      = ram_we_q && ram_ready;
  assign head_vld  = !fifo_empty;
  assign drain_end = (state_q == ST_FLUSH) && fifo_empty && !a_vld_q;

  // Byte address at full width; the final slice wraps modulo the RAM size.
  always_comb begin
    pix_idx   = 32'(in_row) * 32'(img_w_q) + 32'(in_col);
    offset    = dense_q ? 32'(in_index) : pix_idx * 32'(num_ch_q) + 32'(out_ch_q);
    byte_full = {16'd0, base_q, 2'b00} + offset;
    a_addr_d  = byte_full[ADDR_BITS+1:0];
  end

  // Stage A register and configuration latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_vld_q  <= 1'b0;
      a_addr_q <= '0;
      a_val_q  <= '0;
      base_q   <= '0;
      img_w_q  <= '0;
      num_ch_q <= '0;
      out_ch_q <= '0;
      dense_q  <= 1'b0;
    end else begin
      a_vld_q <= accept;
      if (accept) begin
        a_addr_q <= a_addr_d;
        a_val_q  <= in_val;
      end
      if (start_ok) begin
        base_q   <= cfg_base_addr;
        img_w_q  <= cfg_img_w;
        num_ch_q <= cfg_num_ch;
        out_ch_q <= cfg_out_ch;
        dense_q  <= cfg_dense;
      end
    end
  end

  assign push_ent = '{word: a_addr_q[ADDR_BITS+1:2], lane: a_addr_q[1:0], val: a_val_q};

  sync_fifo #(.WIDTH($bits(trw_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (a_vld_q),
    .din_i   (push_ent),
    .pop_i   (fifo_pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Leaves room for the beat in stage A plus the one the source may still send.
  assign stall_req = (32'(fifo_count) + 32'(a_vld_q)) >= 32'(FIFO_DEPTH - 2);

  // Combiner: load/merge the FIFO head, or hand the pending word to the output register.
  always_comb begin
    head_data   = {{(DW-8){1'b0}}, head.val} << {head.lane, 3'b000};
    head_be     = TRW_WORD_BYTES'(1) << head.lane;
    merge_ok    = pend_vld_q && head_vld && (head.word == pend_addr_q) && !pend_be_q[head.lane];
    load        = !pend_vld_q && head_vld;
    issue       = pend_vld_q && (!ram_we_q || ram_ready) &&
                  ((&pend_be_q) || (head_vld && !merge_ok) || drain_end);
    fifo_pop    = load || merge_ok;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_be_d   = pend_be_q;
    ram_we_d    = ram_we_q && !ram_ready;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = ram_be_q;
    if (issue) begin
      pend_vld_d  = 1'b0;
      ram_we_d    = 1'b1;
      ram_addr_d  = pend_addr_q;
      ram_wdata_d = pend_data_q;
      ram_be_d    = pend_be_q;
    end else if (load) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = head.word;
      pend_data_d = head_data;
      pend_be_d   = head_be;
    end else if (merge_ok) begin
      pend_data_d = pend_data_q | head_data;
      pend_be_d   = pend_be_q | head_be;
    end
  end

  // Combiner, output and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_be_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
      overflow_q  <= 1'b0;
      wcount_q    <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_be_q   <= pend_be_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      if (start_ok)                    overflow_q <= 1'b0;
      else if (a_vld_q && fifo_full)   overflow_q <= 1'b1;
      if (start_ok)                       wcount_q <= '0;
      else if (xfer && (wcount_q != 16'hFFFF)) wcount_q <= wcount_q + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; done marks the FLUSH->IDLE cycle.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      ST_FLUSH: if (drain_end && !pend_vld_q && !ram_we_q) begin
        state_d = ST_IDLE;
        done    = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign idle        = (state_q == ST_IDLE);
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_be      = ram_be_q;
  assign overflow    = overflow_q;
  assign write_count = wcount_q;

endmodule
